// File: rtl/wb_periph_ic_1xn.sv
// Single-master, N-slave Wishbone register interconnect with decode error.
// Define WB_PERIPH_IC_TIMEOUT_EN to retire stalled slave accesses with ERR.
module wb_periph_ic_1xn #(
  parameter int N_SLAVES = 4,
  parameter int WB_ADDR_WIDTH = 12,
  parameter int WB_DATA_WIDTH = 32,
  parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE =
    {12'h480, 12'h440, 12'h400, 12'h000},
  parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT =
    {12'h4BF, 12'h44F, 12'h43F, 12'h3FF},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   m_CYC,
  input  logic                                   m_STB,
  input  logic                                   m_WE,
  input  logic [WB_ADDR_WIDTH-1:0]               m_ADR,
  input  logic [WB_DATA_WIDTH-1:0]               m_DAT_W,
  input  logic [WB_DATA_WIDTH/8-1:0]             m_SEL,
  output logic [WB_DATA_WIDTH-1:0]               m_DAT_R,
  output logic                                   m_ACK,
  output logic                                   m_ERR,
  output logic [N_SLAVES-1:0]                    s_CYC,
  output logic [N_SLAVES-1:0]                    s_STB,
  output logic [N_SLAVES-1:0]                    s_WE,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]      s_ADR,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_DAT_W,
  output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]    s_SEL,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_DAT_R,
  input  logic [N_SLAVES-1:0]                    s_ACK,
  input  logic [N_SLAVES-1:0]                    s_ERR,
  output logic                                   to_err
);

  localparam int N  = N_SLAVES;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t        state;
  logic [N-1:0]  sel_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [SW-1:0] be_q;

  logic          hit;
  logic [N-1:0]  hit_oh;
  logic          rsp_ack;
  logic          rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          to_hit;

  // Descending scan so the lowest matching window is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_ADR >= SLAVE_ADDR_BASE[i*AW +: AW] &&
          m_ADR <= SLAVE_ADDR_LIMIT[i*AW +: AW]) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_ack = 1'b0;
    rsp_err = 1'b0;
    rsp_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q[i]) begin
        rsp_ack = s_ACK[i];
        rsp_err = s_ERR[i];
        rsp_dat = s_DAT_R[i*DW +: DW];
      end
    end
  end

  assign s_CYC   = sel_q;
  assign s_STB   = sel_q;
  assign s_WE    = sel_q & {N{we_q}};
  assign s_ADR   = {N{adr_q}};
  assign s_DAT_W = {N{dat_q}};
  assign s_SEL   = {N{be_q}};

`ifdef WB_PERIPH_IC_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign to_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      to_err <= 1'b0;
    end else begin
      cnt    <= (state == ACTIVE) ? cnt + 1'b1 : '0;
      to_err <= (state == ACTIVE) && m_CYC &&
                !rsp_ack && !rsp_err && to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign to_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      be_q    <= '0;
      m_DAT_R <= '0;
      m_ACK   <= 1'b0;
      m_ERR   <= 1'b0;
    end else begin
      m_ACK <= 1'b0;
      m_ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m_CYC && m_STB) begin
            if (hit) begin
              sel_q <= hit_oh;
              we_q  <= m_WE;
              adr_q <= m_ADR;
              dat_q <= m_DAT_W;
              be_q  <= m_SEL;
              state <= ACTIVE;
            end else begin
              m_ERR   <= 1'b1;
              m_DAT_R <= '0;
              state   <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!m_CYC) begin
            sel_q <= '0;
            state <= IDLE;
          end else if (rsp_ack || rsp_err) begin
            sel_q   <= '0;
            m_DAT_R <= rsp_dat;
            m_ERR   <= rsp_err;
            m_ACK   <= !rsp_err;
            state   <= RESP;
          end else if (to_hit) begin
            sel_q <= '0;
            m_ERR <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_periph_ic_1xn.sv
// Randomized bench for wb_periph_ic_1xn against a cycle-count reference model.
// Timeout checks follow WB_PERIPH_IC_TIMEOUT_EN as seen by this compile.
module tb_wb_periph_ic_1xn;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

`ifdef WB_PERIPH_IC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            m_CYC = 1'b0;
  logic            m_STB = 1'b0;
  logic            m_WE = 1'b0;
  logic [AW-1:0]   m_ADR = '0;
  logic [DW-1:0]   m_DAT_W = '0;
  logic [SW-1:0]   m_SEL = '0;
  logic [DW-1:0]   m_DAT_R;
  logic            m_ACK;
  logic            m_ERR;
  logic [N-1:0]    s_CYC;
  logic [N-1:0]    s_STB;
  logic [N-1:0]    s_WE;
  logic [N*AW-1:0] s_ADR;
  logic [N*DW-1:0] s_DAT_W;
  logic [N*SW-1:0] s_SEL;
  logic [N*DW-1:0] s_DAT_R = '0;
  logic [N-1:0]    s_ACK = '0;
  logic [N-1:0]    s_ERR = '0;
  logic            to_err;

  always #5 clk = ~clk;

  wb_periph_ic_1xn #(
    .N_SLAVES(N),
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .SLAVE_ADDR_BASE({12'h480, 12'h440, 12'h400, 12'h000}),
    .SLAVE_ADDR_LIMIT({12'h4BF, 12'h44F, 12'h43F, 12'h3FF}),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .m_CYC(m_CYC),
    .m_STB(m_STB),
    .m_WE(m_WE),
    .m_ADR(m_ADR),
    .m_DAT_W(m_DAT_W),
    .m_SEL(m_SEL),
    .m_DAT_R(m_DAT_R),
    .m_ACK(m_ACK),
    .m_ERR(m_ERR),
    .s_CYC(s_CYC),
    .s_STB(s_STB),
    .s_WE(s_WE),
    .s_ADR(s_ADR),
    .s_DAT_W(s_DAT_W),
    .s_SEL(s_SEL),
    .s_DAT_R(s_DAT_R),
    .s_ACK(s_ACK),
    .s_ERR(s_ERR),
    .to_err(to_err)
  );

  int errs = 0;
  int checks = 0;

  int base[N] = '{'h000, 'h400, 'h440, 'h480};
  int lim[N]  = '{'h3FF, 'h43F, 'h44F, 'h4BF};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input int a);
    for (int i = 0; i < N; i++)
      if (a >= base[i] && a <= lim[i]) return i;
    return -1;
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent; ab: master drop cycle, 0 none
  task automatic run_txn(input logic [AW-1:0] adr, input bit we,
                         input logic [DW-1:0] wd, input logic [SW-1:0] sel,
                         input int w, input int kind, input int ab,
                         input logic [DW-1:0] rd);
    int e, c, r, last, stop;
    bit hit, resp, is_err, is_to;
    logic [N-1:0] exp_stb;
    logic [DW-1:0] exp_dat;
    e = decode(int'(adr));
    hit = (e >= 0);
    c = (kind == 3) ? 1000 : 1 + w;
    resp = 0; is_err = 0; is_to = 0; r = 0; last = 0; exp_dat = '0;
    if (!hit) begin
      resp = 1; is_err = 1; r = 1;
    end else if (kind != 3) begin
      if (ab != 0 && ab <= c) last = ab;
      else begin
        resp = 1; r = c + 1; last = c;
        is_err = (kind != 0); exp_dat = rd;
      end
    end else if (TO_EN && (ab == 0 || ab > TO)) begin
      resp = 1; r = TO + 1; last = TO; is_err = 1; is_to = 1;
    end else begin
      last = ab;
    end
    stop = resp ? r + 1 : last + 2;

    @(negedge clk);
    m_CYC = 1; m_STB = 1; m_WE = we;
    m_ADR = adr; m_DAT_W = wd; m_SEL = sel;
    s_ACK = '0; s_ERR = '0;
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      exp_stb = (hit && k <= last) ? (N'(1) << e) : '0;
      check("s_stb", 64'(s_STB), 64'(exp_stb));
      check("s_cyc", 64'(s_CYC), 64'(exp_stb));
      check("m_ack", 64'(m_ACK), 64'(resp && k == r && !is_err));
      check("m_err", 64'(m_ERR), 64'(resp && k == r && is_err));
      check("to_err", 64'(to_err), 64'(is_to && k == r));
      if (k == 1 && hit) begin
        check("s_we", 64'(s_WE), 64'(we ? exp_stb : '0));
        check("s_adr", 64'(s_ADR[e*AW +: AW]), 64'(adr));
        check("s_dat_w", 64'(s_DAT_W[e*DW +: DW]), 64'(wd));
        check("s_sel", 64'(s_SEL[e*SW +: SW]), 64'(sel));
      end
      if (resp && k == r && (!hit || !is_err))
        check("m_dat_r", 64'(m_DAT_R), 64'(exp_dat));
      m_CYC = !((ab != 0 && k >= ab) || (resp && k >= r));
      m_STB = m_CYC;
      s_ACK = N'($urandom);
      s_ERR = N'($urandom);
      s_DAT_R = {$urandom, $urandom, $urandom, $urandom};
      if (hit) begin
        s_ACK[e] = (k == c) && (kind == 0 || kind == 2);
        s_ERR[e] = (k == c) && (kind == 1 || kind == 2);
        if (k == c) s_DAT_R[e*DW +: DW] = rd;
      end
    end
    m_CYC = 0; m_STB = 0;
  endtask

  initial begin
    int kind, ab;
    logic [AW-1:0] a;
    #12;
    check("rst_ack", 64'(m_ACK), 64'd0);
    check("rst_err", 64'(m_ERR), 64'd0);
    check("rst_dat", 64'(m_DAT_R), 64'd0);
    check("rst_to", 64'(to_err), 64'd0);
    check("rst_stb", 64'(s_STB), 64'd0);
    check("rst_adr", 64'(s_ADR), 64'd0);
    @(negedge clk);
    rstn = 1;

    run_txn(12'h404, 0, 32'h0, 4'hF, 0, 0, 0, 32'hCAFEF00D);
    run_txn(12'h44C, 1, 32'h5A, 4'b0001, 3, 0, 0, 32'h1234);
    run_txn(12'h4C0, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0);
    run_txn(12'h000, 0, 32'h0, 4'hF, 0, 3, TO_EN ? 0 : 20, 32'h0);
    run_txn(12'h480, 0, 32'h0, 4'hF, 10, 0, 2, 32'h77);
    run_txn(12'h000, 1, 32'hA5A5, 4'hC, 0, 0, 0, 32'h99);
    run_txn(12'h43F, 0, 32'h0, 4'hF, 1, 1, 0, 32'h55);
    run_txn(12'h440, 0, 32'h0, 4'hF, 2, 2, 0, 32'h66);
    run_txn(12'h4BF, 0, 32'h0, 4'hF, 0, 0, 0, 32'h87654321);
    run_txn(12'h4A0, 0, 32'h0, 4'hF, 3, 0, 4, 32'h11);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom % 8 == 0) ? AW'($urandom) : AW'($urandom_range(0, 'h4FF));
      kind = $urandom_range(0, 3);
      ab = ($urandom % 4 == 0) ? $urandom_range(1, 10) : 0;
      if (kind == 3 && !TO_EN && ab == 0) ab = $urandom_range(1, 12);
      run_txn(a, 1'($urandom), $urandom, SW'($urandom),
              $urandom_range(0, 5), kind, ab, $urandom);
    end

    // asynchronous reset in the middle of a stalled slave-3 access
    @(negedge clk);
    m_CYC = 1; m_STB = 1; m_WE = 1; m_ADR = 12'h490;
    m_DAT_W = 32'hDEAD; m_SEL = 4'hF; s_ACK = '0; s_ERR = '0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_stb", 64'(s_STB), 64'h8);
    #2 rstn = 0;
    #1;
    check("arst_cyc", 64'(s_CYC), 64'd0);
    check("arst_stb", 64'(s_STB), 64'd0);
    check("arst_we", 64'(s_WE), 64'd0);
    check("arst_adr", 64'(s_ADR), 64'd0);
    check("arst_dat_w", 64'(s_DAT_W != '0), 64'd0);
    check("arst_sel", 64'(s_SEL), 64'd0);
    check("arst_ack", 64'(m_ACK), 64'd0);
    check("arst_err", 64'(m_ERR), 64'd0);
    check("arst_dat_r", 64'(m_DAT_R), 64'd0);
    check("arst_to", 64'(to_err), 64'd0);
    m_CYC = 0; m_STB = 0;
    @(negedge clk);
    rstn = 1;
    run_txn(12'h000, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
